// File: rtl/dio_arb_pkg.sv
// dio_arbiter shared types: FSM state, owner encoding, starve counter width.
package dio_arb_pkg;

    localparam int STARVE_W = 4;

    typedef logic [STARVE_W-1:0] starve_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_BUSY = 2'd1,
        DMA_BUSY = 2'd2
    } arb_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/dio_arb_starve_ctr.sv
// Saturating starvation counter: clear has priority over increment.
module dio_arb_starve_ctr
    import dio_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    clr,
    input  logic    inc,
    output starve_t count
);

    // Count CPU wins over a waiting DMA, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + starve_t'(1);
        end
    end

endmodule

// File: rtl/dio_arbiter.sv
// Data/IO memory port arbiter between the CPU data path and a DMA master.
// Fixed CPU priority; a DMA grant is forced once the CPU has won
// STARVE_LIMIT times in a row against a pending DMA request.
// Optional statistics outputs are enabled by defining DIO_ARB_STATS_EN.
//
//   state    | meaning
//   ---------+----------------------------------
//   IDLE     | no access in flight
//   CPU_BUSY | CPU access held on the memory port
//   DMA_BUSY | DMA access held on the memory port
module dio_arbiter
    import dio_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef DIO_ARB_STATS_EN
    output logic [15:0]       stall_cycles,
    output logic [15:0]       cpu_grants,
    output logic [15:0]       dma_grants,
`endif
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [15:0]       dma_wdata,
    output logic [15:0]       dma_rdata,
    output logic              dma_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam starve_t STARVE_LIM = starve_t'(STARVE_LIMIT);

    arb_state_t state;
    arb_state_t state_nxt;
    starve_t    starve;
    logic       grant_cpu;
    logic       grant_dma;
    logic       grant_owner;
    logic       done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, completion detect and next state.
    always_comb begin
        state_nxt   = state;
        grant_cpu   = 1'b0;
        grant_dma   = 1'b0;
        grant_owner = OWNER_CPU;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                grant_cpu = cpu_req & (~dma_req | (starve < STARVE_LIM));
                grant_dma = dma_req & ~grant_cpu;
                if (grant_cpu) begin
                    state_nxt = CPU_BUSY;
                end else if (grant_dma) begin
                    state_nxt   = DMA_BUSY;
                    grant_owner = OWNER_DMA;
                end
            end
            CPU_BUSY, DMA_BUSY: begin
                done = mem_ready;
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The CPU may advance in the very cycle its access completes.
    assign cpu_stall = cpu_req & ~((state == CPU_BUSY) & mem_ready);

    // Latch the winner onto the memory port and return read data on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            dma_ack   <= 1'b0;
        end else begin
            dma_ack <= 1'b0;
            if (grant_cpu || grant_dma) begin
                mem_req <= 1'b1;
                if (grant_owner == OWNER_DMA) begin
                    mem_we    <= dma_we;
                    mem_addr  <= dma_addr;
                    mem_wdata <= dma_wdata;
                end else begin
                    mem_we    <= cpu_we;
                    mem_addr  <= cpu_addr;
                    mem_wdata <= cpu_wdata;
                end
            end else if (done) begin
                mem_req <= 1'b0;
                if (state == DMA_BUSY) begin
                    dma_ack <= 1'b1;
                    if (!mem_we) begin
                        dma_rdata <= mem_rdata;
                    end
                end else if (!mem_we) begin
                    cpu_rdata <= mem_rdata;
                end
            end
        end
    end

    dio_arb_starve_ctr u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (grant_dma | ~dma_req),
        .inc   (grant_cpu & dma_req),
        .count (starve)
    );

`ifdef DIO_ARB_STATS_EN
    // Stall cycles saturate; grant counts wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            cpu_grants   <= '0;
            dma_grants   <= '0;
        end else begin
            if (cpu_stall && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (grant_cpu) begin
                cpu_grants <= cpu_grants + 16'd1;
            end
            if (grant_dma) begin
                dma_grants <= dma_grants + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dio_arbiter.sv
// Directed testbench for dio_arbiter: per-cycle vector table plus
// hand-written arbitration, idle-ready and reset sequences.
module tb_dio_arbiter;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we, mem_ready;
    logic [31:0] cpu_addr, dma_addr;
    logic [15:0] cpu_wdata, dma_wdata, mem_rdata;
    logic [15:0] cpu_rdata, dma_rdata, mem_wdata;
    logic        cpu_stall, dma_ack, mem_req, mem_we;
    logic [31:0] mem_addr;
`ifdef DIO_ARB_STATS_EN
    logic [15:0] stall_cycles, cpu_grants, dma_grants;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int ack_cnt = 0;
    logic [15:0] last_cpu_rd, last_dma_rd;

    dio_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef DIO_ARB_STATS_EN
        .stall_cycles(stall_cycles), .cpu_grants(cpu_grants), .dma_grants(dma_grants),
`endif
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (dma_ack === 1'b1) ack_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [31:0] cpu_addr;
        logic [15:0] cpu_wdata;
        logic        dma_req;
        logic        dma_we;
        logic [31:0] dma_addr;
        logic [15:0] dma_wdata;
        logic        mem_ready;
        logic [15:0] mem_rdata;
        logic        e_mem_req;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic [15:0] e_mem_wdata;
        logic        e_stall;
        logic [15:0] e_cpu_rdata;
        logic        e_dma_ack;
        logic [15:0] e_dma_rdata;
    } vec_t;

    vec_t rows [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            cpu_req   = rows[i].cpu_req;   cpu_we    = rows[i].cpu_we;
            cpu_addr  = rows[i].cpu_addr;  cpu_wdata = rows[i].cpu_wdata;
            dma_req   = rows[i].dma_req;   dma_we    = rows[i].dma_we;
            dma_addr  = rows[i].dma_addr;  dma_wdata = rows[i].dma_wdata;
            mem_ready = rows[i].mem_ready; mem_rdata = rows[i].mem_rdata;
            @(negedge clk);
            chk($sformatf("row%0d mem_req", i), {31'd0, mem_req}, {31'd0, rows[i].e_mem_req});
            if (rows[i].e_mem_req) begin
                chk($sformatf("row%0d mem_we", i), {31'd0, mem_we}, {31'd0, rows[i].e_mem_we});
                chk($sformatf("row%0d mem_addr", i), mem_addr, rows[i].e_mem_addr);
                chk($sformatf("row%0d mem_wdata", i), {16'd0, mem_wdata}, {16'd0, rows[i].e_mem_wdata});
            end
            chk($sformatf("row%0d cpu_stall", i), {31'd0, cpu_stall}, {31'd0, rows[i].e_stall});
            chk($sformatf("row%0d cpu_rdata", i), {16'd0, cpu_rdata}, {16'd0, rows[i].e_cpu_rdata});
            chk($sformatf("row%0d dma_ack", i), {31'd0, dma_ack}, {31'd0, rows[i].e_dma_ack});
            chk($sformatf("row%0d dma_rdata", i), {16'd0, dma_rdata}, {16'd0, rows[i].e_dma_rdata});
            @(posedge clk); #1;
        end
    endtask

    // Both masters request continuously (reads); memory answers one cycle
    // after mem_req rises. Returns grant order, bit k set = k-th grant went to DMA.
    task automatic run_arb(input int n, output logic [15:0] seq, output int got);
        int busy;
        bit fin;
        busy = 0; got = 0; seq = '0; fin = 0;
        cpu_we = 1'b0; cpu_addr = 32'h100; cpu_wdata = 16'h0;
        dma_we = 1'b0; dma_addr = 32'h200; dma_wdata = 16'h0;
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int cyc = 0; cyc < n * 3 + 20; cyc++) begin
            if (mem_req) busy++; else busy = 0;
            if (busy == 1) begin
                if (got < 16) seq[got] = (mem_addr == 32'h200);
                got++;
            end
            mem_ready = (busy == 2);
            mem_rdata = 16'hA000 + 16'(cyc);
            if (busy == 2) begin
                if (mem_addr == 32'h100) last_cpu_rd = mem_rdata;
                else last_dma_rd = mem_rdata;
                if (got == n) fin = 1;
            end
            @(posedge clk); #1;
            if (fin) break;
        end
        mem_ready = 1'b0;
    endtask

    logic [15:0] seq;
    int          got;

    initial begin
        // A = CPU addr, W = CPU wdata (reads still latch wdata onto the port).
        rows[0]  = '{H,L,32'h1234,16'h7777, L,L,32'h0,16'h0, L,16'h0,    L,L,32'h1234,16'h7777, H,16'h0000,L,16'h0};
        rows[1]  = '{H,L,32'h1234,16'h7777, L,L,32'h0,16'h0, L,16'h0,    H,L,32'h1234,16'h7777, H,16'h0000,L,16'h0};
        rows[2]  = rows[1];
        rows[3]  = rows[1];
        rows[4]  = '{H,L,32'h1234,16'h7777, L,L,32'h0,16'h0, H,16'hBEEF, H,L,32'h1234,16'h7777, L,16'h0000,L,16'h0};
        rows[5]  = '{L,L,32'h1234,16'h7777, L,L,32'h0,16'h0, L,16'h0,    L,L,32'h1234,16'h7777, L,16'hBEEF,L,16'h0};
        rows[6]  = '{H,L,32'h1234,16'h7777, L,L,32'h0,16'h0, L,16'h0,    L,L,32'h1234,16'h7777, H,16'hBEEF,L,16'h0};
        rows[7]  = '{H,L,32'h1234,16'h7777, L,L,32'h0,16'h0, L,16'h0,    H,L,32'h1234,16'h7777, H,16'hBEEF,L,16'h0};
        rows[8]  = rows[7];
        rows[9]  = rows[7];
        rows[10] = '{H,L,32'h1234,16'h7777, L,L,32'h0,16'h0, H,16'hC0DE, H,L,32'h1234,16'h7777, L,16'hBEEF,L,16'h0};
        rows[11] = '{L,L,32'h1234,16'h7777, L,L,32'h0,16'h0, L,16'h0,    L,L,32'h1234,16'h7777, L,16'hC0DE,L,16'h0};
        rows[12] = '{L,L,32'h0,16'h0, H,H,32'h10,16'h5A5A, L,16'h0,    L,H,32'h10,16'h5A5A, L,16'hC0DE,L,16'h0};
        rows[13] = '{L,L,32'h0,16'h0, H,H,32'h20,16'h1111, L,16'h0,    H,H,32'h10,16'h5A5A, L,16'hC0DE,L,16'h0};
        rows[14] = '{L,L,32'h0,16'h0, H,H,32'h20,16'h1111, H,16'hFFFF, H,H,32'h10,16'h5A5A, L,16'hC0DE,L,16'h0};
        rows[15] = '{L,L,32'h0,16'h0, L,H,32'h20,16'h1111, L,16'h0,    L,H,32'h10,16'h5A5A, L,16'hC0DE,H,16'h0};
        rows[16] = '{L,L,32'h0,16'h0, L,L,32'h0,16'h0,     L,16'h0,    L,L,32'h10,16'h0,    L,16'hC0DE,L,16'h0};

        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        last_cpu_rd = 0; last_dma_rd = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("reset cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        chk("reset dma_rdata", {16'd0, dma_rdata}, 32'd0);
        chk("reset dma_ack", {31'd0, dma_ack}, 32'd0);
        chk("reset cpu_stall", {31'd0, cpu_stall}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // CPU read twice, then DMA write.
        apply_rows(0, 11);
`ifdef DIO_ARB_STATS_EN
        chk("stats stall_cycles", {16'd0, stall_cycles}, 32'd8);
        chk("stats cpu_grants", {16'd0, cpu_grants}, 32'd2);
        chk("stats dma_grants", {16'd0, dma_grants}, 32'd0);
`endif
        apply_rows(12, 16);

        // Continuous contention: C,C,C,C,D twice.
        run_arb(10, seq, got);
        chk("contend grant count", got, 32'd10);
        chk("contend grant order", {16'd0, seq}, 32'h0210);
        // Three more CPU wins: starve counter now at 3.
        run_arb(3, seq, got);
        chk("pre-idle grant count", got, 32'd3);
        chk("pre-idle grant order", {16'd0, seq}, 32'h0000);

        // mem_ready in IDLE with dma_req dropped: ignored, starve clears.
        cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        chk("idle ready cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("idle ready mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("idle ready mem_req after", {31'd0, mem_req}, 32'd0);
        chk("idle ready dma_ack", {31'd0, dma_ack}, 32'd0);
        chk("idle ready cpu_rdata kept", {16'd0, cpu_rdata}, {16'd0, last_cpu_rd});
        chk("idle ready dma_rdata kept", {16'd0, dma_rdata}, {16'd0, last_dma_rd});
        @(posedge clk); #1;
        run_arb(5, seq, got);
        chk("post-clear grant count", got, 32'd5);
        chk("post-clear grant order", {16'd0, seq}, 32'h0010);
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("dma_ack pulse total", ack_cnt, 32'd4);
        chk("dma_rdata last read", {16'd0, dma_rdata}, {16'd0, last_dma_rd});

        // Reset in the middle of a CPU access.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3000; cpu_wdata = 16'h9999;
        @(posedge clk); #1;
        chk("prereset mem_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("async reset mem_req", {31'd0, mem_req}, 32'd0);
        chk("async reset mem_addr", mem_addr, 32'd0);
        chk("async reset mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("async reset cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        chk("async reset dma_rdata", {16'd0, dma_rdata}, 32'd0);
`ifdef DIO_ARB_STATS_EN
        chk("async reset stall_cycles", {16'd0, stall_cycles}, 32'd0);
        chk("async reset cpu_grants", {16'd0, cpu_grants}, 32'd0);
`endif
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post-reset quiet%0d dma_ack", k), {31'd0, dma_ack}, 32'd0);
            chk($sformatf("post-reset quiet%0d mem_req", k), {31'd0, mem_req}, 32'd0);
            @(posedge clk); #1;
        end
        chk("post-reset ack total", ack_cnt, 32'd4);

        // Normal CPU read after reset release.
        cpu_req = 1'b1;
        @(negedge clk);
        chk("after reset grant idle stall", {31'd0, cpu_stall}, 32'd1);
        @(posedge clk); #1;
        mem_ready = 1'b1; mem_rdata = 16'h4242;
        @(negedge clk);
        chk("after reset mem_req", {31'd0, mem_req}, 32'd1);
        chk("after reset mem_addr", mem_addr, 32'h3000);
        chk("after reset stall released", {31'd0, cpu_stall}, 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("after reset cpu_rdata", {16'd0, cpu_rdata}, 32'h4242);
        chk("after reset mem_req drop", {31'd0, mem_req}, 32'd0);
`ifdef DIO_ARB_STATS_EN
        chk("after reset stall_cycles", {16'd0, stall_cycles}, 32'd1);
        chk("after reset cpu_grants", {16'd0, cpu_grants}, 32'd1);
        chk("after reset dma_grants", {16'd0, dma_grants}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
